// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM port arbiter.
package sram_arb_pkg;

    // Default byte address width; SRAM word address is SRAM_AW-2 bits.
    localparam int SRAM_AW   = 16;
    localparam int SRAM_DW   = 32;
    localparam int SRAM_BE_W = 4;

    // One SRAM macro request as driven onto the macro pins.
    typedef struct packed {
        logic                 cs;
        logic [SRAM_AW-3:0]   addr;
        logic [SRAM_BE_W-1:0] wen;
        logic [SRAM_DW-1:0]   wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bridge port (A), secondary requester port (B) and SRAM macro pins.
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int AW = 16
) ();
    logic                 A_CS;
    logic [AW-3:0]        A_ADDR;
    logic [SRAM_BE_W-1:0] A_WEN;
    logic [SRAM_DW-1:0]   A_WDATA;
    logic [SRAM_DW-1:0]   A_RDATA;

    logic                 B_REQ_VALID;
    logic                 B_REQ_READY;
    logic                 B_WRITE;
    logic [AW-3:0]        B_ADDR;
    logic [SRAM_BE_W-1:0] B_WSTRB;
    logic [SRAM_DW-1:0]   B_WDATA;
    logic                 B_RVALID;
    logic [SRAM_DW-1:0]   B_RDATA;

    logic [SRAM_DW-1:0]   SRAMRDATA;
    logic [AW-3:0]        SRAMADDR;
    logic [SRAM_BE_W-1:0] SRAMWEN;
    logic [SRAM_DW-1:0]   SRAMWDATA;
    logic                 SRAMCS;

    // Arbiter side.
    modport slave (
        input  A_CS, A_ADDR, A_WEN, A_WDATA,
        output A_RDATA,
        input  B_REQ_VALID, B_WRITE, B_ADDR, B_WSTRB, B_WDATA,
        output B_REQ_READY, B_RVALID, B_RDATA,
        input  SRAMRDATA,
        output SRAMADDR, SRAMWEN, SRAMWDATA, SRAMCS
    );

    // Requesters plus SRAM macro side.
    modport master (
        output A_CS, A_ADDR, A_WEN, A_WDATA,
        input  A_RDATA,
        output B_REQ_VALID, B_WRITE, B_ADDR, B_WSTRB, B_WDATA,
        input  B_REQ_READY, B_RVALID, B_RDATA,
        output SRAMRDATA,
        input  SRAMADDR, SRAMWEN, SRAMWDATA, SRAMCS
    );
endinterface

// File: rtl/sram_arb_starve_mon.sv
// Counts consecutive cycles in which B is requesting but blocked by A,
// and flags starvation once the count reaches STARVE_LIMIT.
module sram_arb_starve_mon #(
    parameter int STARVE_LIMIT = 64,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic blocked,
    input  logic gnt,
    output logic starve
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             starve_d, starve_q;

    // Saturating denial count; any grant or dropped request restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (gnt || !req_valid) begin
            cnt_d = '0;
        end else if (blocked && cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Flag follows the next count so it drops together with the clear.
        starve_d = (cnt_d == LIMIT);
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
endmodule

// File: rtl/sram_port_arbiter.sv
// Fixed-priority arbiter: the AHB bridge (A) always owns the SRAM when it
// selects it; the secondary requester (B) gets the leftover cycles.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW           = SRAM_AW,
    parameter int STARVE_LIMIT = 64,
    parameter int CNT_W        = 8
) (
    input  logic                HCLK,
    input  logic                HRESET,
    sram_port_arbiter_if.slave  bus,
    output logic                STARVE,
    output logic                HAZARD
);
    logic            b_ready;
    logic            gnt_b;
    sram_req_t       req_mux;
    logic            starve_raw;

    logic            rd_pend_d, rd_pend_q;
    logic [SRAM_DW-1:0] rdata_hold_d, rdata_hold_q;
    logic            hazard_d, hazard_q;
    logic            last_a_vld_d, last_a_vld_q;
    logic [AW-3:0]   last_a_addr_d, last_a_addr_q;

    assign b_ready = ~bus.A_CS & ~HRESET;
    assign gnt_b   = bus.B_REQ_VALID & b_ready;

    // SRAM pin mux: A first, then a granted B, else idle with A's bus parked.
    always_comb begin
        req_mux = '{cs: 1'b0, addr: bus.A_ADDR, wen: '0, wdata: bus.A_WDATA};
        if (bus.A_CS) begin
            req_mux = '{cs: 1'b1, addr: bus.A_ADDR, wen: bus.A_WEN, wdata: bus.A_WDATA};
        end else if (gnt_b) begin
            req_mux = '{cs: 1'b1, addr: bus.B_ADDR,
                        wen: bus.B_WRITE ? bus.B_WSTRB : '0, wdata: bus.B_WDATA};
        end
    end

    assign bus.SRAMCS      = req_mux.cs;
    assign bus.SRAMADDR    = req_mux.addr;
    assign bus.SRAMWEN     = req_mux.wen;
    assign bus.SRAMWDATA   = req_mux.wdata;
    assign bus.B_REQ_READY = b_ready;
    assign bus.A_RDATA     = bus.SRAMRDATA;

    // Next state for the B read return and the A-write hazard tracker.
    always_comb begin
        rd_pend_d     = gnt_b & ~bus.B_WRITE;
        rdata_hold_d  = rd_pend_q ? bus.SRAMRDATA : rdata_hold_q;
        hazard_d      = gnt_b & bus.B_WRITE & (|bus.B_WSTRB) & last_a_vld_q &
                        (bus.B_ADDR == last_a_addr_q);
        last_a_vld_d  = last_a_vld_q;
        last_a_addr_d = last_a_addr_q;
        if (bus.A_CS && (|bus.A_WEN)) begin
            last_a_vld_d  = 1'b1;
            last_a_addr_d = bus.A_ADDR;
        end
    end

    // Return-path and hazard registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_pend_q     <= 1'b0;
            rdata_hold_q  <= '0;
            hazard_q      <= 1'b0;
            last_a_vld_q  <= 1'b0;
            last_a_addr_q <= '0;
        end else begin
            rd_pend_q     <= rd_pend_d;
            rdata_hold_q  <= rdata_hold_d;
            hazard_q      <= hazard_d;
            last_a_vld_q  <= last_a_vld_d;
            last_a_addr_q <= last_a_addr_d;
        end
    end

    // Status outputs are forced quiet during reset, including a read return
    // that was granted just before reset arrived.
    assign bus.B_RVALID = rd_pend_q & ~HRESET;
    assign bus.B_RDATA  = HRESET ? '0 : (rd_pend_q ? bus.SRAMRDATA : rdata_hold_q);
    assign HAZARD       = hazard_q & ~HRESET;
    assign STARVE       = starve_raw & ~HRESET;

    sram_arb_starve_mon #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_mon (
        .clk       (HCLK),
        .rst       (HRESET),
        .req_valid (bus.B_REQ_VALID),
        .blocked   (bus.A_CS),
        .gnt       (gnt_b),
        .starve    (starve_raw)
    );
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM macro model, behavioural reference,
// table vectors, directed corner sequences and randomized traffic.
module tb_sram_port_arbiter;
    localparam int AW    = 16;
    localparam int LIMIT = 64;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.AW(AW)) bus ();
    logic starve, hazard;

    sram_port_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
        .HCLK(clk), .HRESET(rst), .bus(bus), .STARVE(starve), .HAZARD(hazard)
    );

    // Stimulus variables
    logic        a_cs, b_valid, b_write;
    logic [13:0] a_addr, b_addr;
    logic [3:0]  a_wen, b_wstrb;
    logic [31:0] a_wdata, b_wdata;
    assign bus.A_CS = a_cs;       assign bus.A_ADDR = a_addr;
    assign bus.A_WEN = a_wen;     assign bus.A_WDATA = a_wdata;
    assign bus.B_REQ_VALID = b_valid; assign bus.B_WRITE = b_write;
    assign bus.B_ADDR = b_addr;   assign bus.B_WSTRB = b_wstrb;
    assign bus.B_WDATA = b_wdata;

    function automatic logic [31:0] init_val(int i);
        return (i == 16) ? 32'hDEADBEEF : (32'h5A00_0000 ^ (i * 32'h0001_0003));
    endfunction

    // SRAM macro model: byte-enable writes, registered read data; random
    // garbage on the data pins in cycles without a chip select.
    logic [31:0] mem [0:1023];
    logic [31:0] sram_q;
    bit          loaded = 1'b0;
    assign bus.SRAMRDATA = sram_q;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
            sram_q <= $urandom;
        end else if (bus.SRAMCS) begin
            for (int b = 0; b < 4; b++)
                if (bus.SRAMWEN[b]) mem[bus.SRAMADDR[9:0]][b*8 +: 8] <= bus.SRAMWDATA[b*8 +: 8];
            sram_q <= mem[bus.SRAMADDR[9:0]];
        end else begin
            sram_q <= $urandom;
        end
    end

    // Reference model state
    logic [31:0] refmem [0:1023];
    logic [31:0] ret_q[$];
    logic [31:0] m_hold;
    int          m_denied;
    bit          m_hazard, m_last_vld;
    logic [13:0] m_last_addr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit rdy, gnt;
        logic [13:0] e_addr;
        logic [3:0]  e_wen;
        logic [31:0] e_wdata;
        rdy = !rst && !a_cs;
        gnt = b_valid && rdy;
        e_addr  = (!a_cs && gnt) ? b_addr : a_addr;
        e_wdata = (!a_cs && gnt) ? b_wdata : a_wdata;
        e_wen   = a_cs ? a_wen : ((gnt && b_write) ? b_wstrb : 4'h0);
        chk("m_ready", bus.B_REQ_READY, rdy);
        chk("m_sramcs", bus.SRAMCS, a_cs | gnt);
        chk("m_sramaddr", bus.SRAMADDR, e_addr);
        chk("m_sramwen", bus.SRAMWEN, e_wen);
        chk("m_sramwdata", bus.SRAMWDATA, e_wdata);
        chk("m_ardata", bus.A_RDATA, sram_q);
        chk("m_rvalid", bus.B_RVALID, !rst && ret_q.size() > 0);
        chk("m_rdata", bus.B_RDATA, rst ? 32'h0 : (ret_q.size() > 0 ? ret_q[0] : m_hold));
        chk("m_starve", starve, !rst && m_denied >= LIMIT);
        chk("m_hazard", hazard, !rst && m_hazard);
    endtask

    task automatic model_update();
        bit gnt;
        gnt = b_valid && !rst && !a_cs;
        if (rst) begin
            ret_q.delete();
            m_hold = 0; m_denied = 0; m_hazard = 0;
            m_last_vld = 0; m_last_addr = 0;
        end else begin
            if (ret_q.size() > 0) m_hold = ret_q.pop_front();
            if (gnt && !b_write) ret_q.push_back(refmem[b_addr[9:0]]);
            m_hazard = gnt && b_write && (|b_wstrb) && m_last_vld && (b_addr == m_last_addr);
            if (a_cs && (|a_wen)) begin m_last_vld = 1; m_last_addr = a_addr; end
            if (b_valid && a_cs) m_denied++;
            else m_denied = 0;
        end
        for (int b = 0; b < 4; b++) begin
            if (a_cs && a_wen[b]) refmem[a_addr[9:0]][b*8 +: 8] = a_wdata[b*8 +: 8];
            else if (!a_cs && gnt && b_write && b_wstrb[b]) refmem[b_addr[9:0]][b*8 +: 8] = b_wdata[b*8 +: 8];
        end
    endtask

    task automatic tick_check(); @(negedge clk); model_check(); endtask
    task automatic tick_end();   @(posedge clk); model_update(); #1; endtask
    task automatic step();       tick_check(); tick_end(); endtask

    task automatic idle_inputs();
        a_cs = 0; a_addr = 0; a_wen = 0; a_wdata = 0;
        b_valid = 0; b_write = 0; b_addr = 0; b_wstrb = 0; b_wdata = 0;
    endtask

    typedef struct {
        bit a_cs; logic [13:0] a_addr; logic [3:0] a_wen; logic [31:0] a_wdata;
        bit b_valid; bit b_write; logic [13:0] b_addr; logic [3:0] b_wstrb; logic [31:0] b_wdata;
        bit e_ready; bit e_cs; logic [13:0] e_addr; logic [3:0] e_wen; logic [31:0] e_wdata;
    } vec_t;
    vec_t vecs [6];

    initial begin
        for (int i = 0; i < 1024; i++) refmem[i] = init_val(i);
        m_hold = 0; m_denied = 0; m_hazard = 0; m_last_vld = 0; m_last_addr = 0;
        idle_inputs();
        rst = 1;
        repeat (3) step();
        tick_check();
        chk("rst_ready", bus.B_REQ_READY, 0);
        chk("rst_rvalid", bus.B_RVALID, 0);
        chk("rst_starve", starve, 0);
        tick_end();
        rst = 0;
        step();

        // Single-cycle mux vectors
        vecs[0] = '{1, 14'h005, 4'h0, 32'h0, 0, 0, 14'h0, 4'h0, 32'h0,
                    0, 1, 14'h005, 4'h0, 32'h0};
        vecs[1] = '{1, 14'h006, 4'hF, 32'h11112222, 1, 0, 14'h007, 4'h0, 32'h0,
                    0, 1, 14'h006, 4'hF, 32'h11112222};
        vecs[2] = '{0, 14'h001, 4'h0, 32'h0, 1, 1, 14'h008, 4'h5, 32'h33334444,
                    1, 1, 14'h008, 4'h5, 32'h33334444};
        vecs[3] = '{0, 14'h001, 4'h0, 32'h0, 1, 0, 14'h009, 4'hF, 32'h55556666,
                    1, 1, 14'h009, 4'h0, 32'h55556666};
        vecs[4] = '{0, 14'h00A, 4'h0, 32'h77778888, 0, 1, 14'h00B, 4'hF, 32'h99990000,
                    1, 0, 14'h00A, 4'h0, 32'h77778888};
        vecs[5] = '{1, 14'h00C, 4'h3, 32'hAAAABBBB, 1, 1, 14'h00D, 4'hF, 32'hCCCCDDDD,
                    0, 1, 14'h00C, 4'h3, 32'hAAAABBBB};
        for (int i = 0; i < 6; i++) begin
            a_cs = vecs[i].a_cs; a_addr = vecs[i].a_addr; a_wen = vecs[i].a_wen;
            a_wdata = vecs[i].a_wdata; b_valid = vecs[i].b_valid; b_write = vecs[i].b_write;
            b_addr = vecs[i].b_addr; b_wstrb = vecs[i].b_wstrb; b_wdata = vecs[i].b_wdata;
            tick_check();
            chk($sformatf("vec%0d_ready", i), bus.B_REQ_READY, vecs[i].e_ready);
            chk($sformatf("vec%0d_cs", i), bus.SRAMCS, vecs[i].e_cs);
            chk($sformatf("vec%0d_addr", i), bus.SRAMADDR, vecs[i].e_addr);
            chk($sformatf("vec%0d_wen", i), bus.SRAMWEN, vecs[i].e_wen);
            chk($sformatf("vec%0d_wdata", i), bus.SRAMWDATA, vecs[i].e_wdata);
            tick_end();
        end
        idle_inputs();
        step();

        // B read of a preloaded word with A idle
        b_valid = 1; b_write = 0; b_addr = 14'h010;
        tick_check();
        chk("rd_ready", bus.B_REQ_READY, 1);
        chk("rd_cs", bus.SRAMCS, 1);
        chk("rd_wen", bus.SRAMWEN, 0);
        tick_end();
        b_valid = 0;
        tick_check();
        chk("rd_rvalid", bus.B_RVALID, 1);
        chk("rd_rdata", bus.B_RDATA, 32'hDEADBEEF);
        tick_end();
        tick_check();
        chk("rd_rvalid_drop", bus.B_RVALID, 0);
        chk("rd_rdata_hold", bus.B_RDATA, 32'hDEADBEEF);
        tick_end();

        // Long A occupancy starves B
        a_cs = 1; a_wen = 0; a_addr = 14'h020;
        b_valid = 1; b_write = 0; b_addr = 14'h011;
        for (int k = 1; k <= 70; k++) begin
            tick_check();
            chk("stv_ready", bus.B_REQ_READY, 0);
            chk("stv_addr", bus.SRAMADDR, 14'h020);
            if (k == 64) chk("stv_before", starve, 0);
            if (k == 65) chk("stv_rise", starve, 1);
            tick_end();
        end
        a_cs = 0;
        tick_check();
        chk("stv_grant", bus.B_REQ_READY, 1);
        chk("stv_still", starve, 1);
        tick_end();
        b_valid = 0;
        tick_check();
        chk("stv_clear", starve, 0);
        chk("stv_rvalid", bus.B_RVALID, 1);
        tick_end();

        // Alternating A with a stream of B half-word writes
        begin
            int idx = 0;
            for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
                bit g;
                a_cs = (cyc % 2 == 0); a_wen = 0; a_addr = 14'h030;
                b_valid = 1; b_write = 1; b_addr = 14'h040 + 14'(idx);
                b_wstrb = 4'b0011; b_wdata = 32'h0000A5A5;
                g = !a_cs;
                tick_check();
                tick_end();
                if (g) idx++;
            end
            chk("alt_done", idx, 4);
        end
        idle_inputs();
        step();
        for (int i = 0; i < 4; i++) begin
            chk("alt_lo", mem[10'h040 + 10'(i)][15:0], 16'hA5A5);
            chk("alt_hi", mem[10'h040 + 10'(i)][31:16], init_val(64 + i) >> 16);
        end

        // Hazard: B write to the word A just wrote
        a_cs = 1; a_addr = 14'h020; a_wen = 4'hF; a_wdata = 32'h12345678;
        step();
        idle_inputs();
        b_valid = 1; b_write = 1; b_addr = 14'h020; b_wstrb = 4'hF; b_wdata = 32'h9ABCDEF0;
        tick_check(); chk("hz_ready", bus.B_REQ_READY, 1); tick_end();
        b_valid = 0;
        tick_check(); chk("hz_pulse", hazard, 1); tick_end();
        tick_check(); chk("hz_once", hazard, 0); tick_end();
        b_valid = 1; b_addr = 14'h024;
        step();
        b_valid = 0;
        tick_check(); chk("hz_other", hazard, 0); tick_end();
        chk("hz_write_done", mem[10'h020], 32'h9ABCDEF0);

        // Reset right after a B read grant
        b_valid = 1; b_write = 0; b_addr = 14'h012;
        tick_check(); chk("rr_ready", bus.B_REQ_READY, 1); tick_end();
        rst = 1; b_valid = 0;
        a_cs = 1; a_addr = 14'h060; a_wen = 4'hF; a_wdata = 32'hCAFE0001;
        tick_check();
        chk("rr_rvalid", bus.B_RVALID, 0);
        chk("rr_rdata", bus.B_RDATA, 0);
        chk("rr_ready_rst", bus.B_REQ_READY, 0);
        chk("rr_a_cs", bus.SRAMCS, 1);
        chk("rr_a_addr", bus.SRAMADDR, 14'h060);
        chk("rr_a_wen", bus.SRAMWEN, 4'hF);
        tick_end();
        rst = 0; idle_inputs();
        tick_check(); chk("rr_after", bus.B_RVALID, 0); tick_end();
        chk("rr_a_write", mem[10'h060], 32'hCAFE0001);

        // B write with empty strobe to A's last word
        a_cs = 1; a_addr = 14'h050; a_wen = 4'hF; a_wdata = 32'h0BADF00D;
        step();
        idle_inputs();
        b_valid = 1; b_write = 1; b_addr = 14'h050; b_wstrb = 4'h0; b_wdata = 32'hFFFFFFFF;
        tick_check();
        chk("z_ready", bus.B_REQ_READY, 1);
        chk("z_cs", bus.SRAMCS, 1);
        chk("z_wen", bus.SRAMWEN, 0);
        tick_end();
        b_valid = 0;
        tick_check(); chk("z_hazard", hazard, 0); tick_end();
        chk("z_mem", mem[10'h050], 32'h0BADF00D);

        // Randomized traffic against the reference model
        begin
            int a_pct = 50;
            idle_inputs();
            for (int c = 0; c < 3000; c++) begin
                bit granted;
                if (c % 100 == 0) begin
                    case ($urandom_range(0, 3))
                        0: a_pct = 0;
                        1: a_pct = 30;
                        2: a_pct = 70;
                        default: a_pct = 100;
                    endcase
                end
                rst = ($urandom_range(0, 499) == 0);
                a_cs = ($urandom_range(0, 99) < a_pct);
                a_addr = 14'($urandom_range(0, 15));
                a_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                a_wdata = $urandom;
                tick_check();
                granted = b_valid && !rst && !a_cs;
                tick_end();
                if (!b_valid || granted) begin
                    b_valid = ($urandom_range(0, 9) < 7);
                    b_write = $urandom_range(0, 1);
                    b_addr = 14'($urandom_range(0, 15));
                    b_wstrb = 4'($urandom);
                    b_wdata = $urandom;
                end
            end
            rst = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
